// File: rtl/lfs_pkg.sv
// Shared types and constants for line_fetch_scheduler: NES-to-VGA geometry,
// trigger rows and the palette index type.
package lfs_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int X_OFFSET = 64;
  localparam int NES_W    = 256;
  localparam int NES_H    = 240;
  localparam int IDX_W    = 6;
  localparam int ADDR_W   = 16;
  localparam int NES_XW   = 8;

  typedef logic [IDX_W-1:0] pal_idx_t;

  localparam pal_idx_t BORDER_IDX = 6'h0F;

  // Row on which line 0 is prefetched, and the first even row that no longer
  // prefetches (the last NES line is already resident by then).
  localparam logic [9:0] LINE0_TRIG_Y  = 10'(V_TOTAL - 1);
  localparam logic [9:0] TRIG_Y_LIMIT  = 10'(V_ACTIVE - 2);

  localparam logic [9:0] WIN_X_LO = 10'(X_OFFSET);
  localparam logic [9:0] WIN_X_HI = 10'(X_OFFSET + 2 * NES_W);
  localparam logic [9:0] WIN_Y_HI = 10'(V_ACTIVE);

  localparam logic [NES_XW-1:0] LAST_X = NES_XW'(NES_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} lfs_state_t;

  function automatic logic [ADDR_W-1:0] line_base_addr(input logic [NES_XW-1:0] line);
    return {line, {NES_XW{1'b0}}};
  endfunction

endpackage

// File: rtl/line_buffer_2x.sv
// Ping-pong line store: two NES_W-entry banks of palette indices with one
// synchronous write port and one synchronous read port, each with a bank select.
module line_buffer_2x
  import lfs_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [NES_XW-1:0] i_wr_addr,
  input  pal_idx_t          i_wr_data,
  input  logic              i_rd_bank,
  input  logic [NES_XW-1:0] i_rd_addr,
  output pal_idx_t          o_rd_data
);

  pal_idx_t r_bank0 [NES_W];
  pal_idx_t r_bank1 [NES_W];
  pal_idx_t r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_wr_bank) r_bank0[i_wr_addr] <= i_wr_data;
    if (i_wr_en &&  i_wr_bank) r_bank1[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    r_rd_data <= i_rd_bank ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_fetch_scheduler.sv
// Fetches NES scanlines into a ping-pong buffer ahead of the VGA beam and
// serves 2x-scaled palette indices. Define LFS_UNDERRUN_CNT_EN for the underrun counter.
module line_fetch_scheduler
  import lfs_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  pal_idx_t          mem_rdata,
  output pal_idx_t          pix_index,
  output logic              pix_valid,
  output logic              line_ready,
  output logic              underrun,
  output logic [7:0]        underrun_cnt,
  output lfs_state_t        dbg_state
);

  // Memory handshake: a word transfers on every cycle where mem_req and mem_ack
  // are both high, and mem_rdata is consumed in that same cycle. mem_req stays
  // high until the last word; mem_addr moves only after a transfer or when a new
  // trigger pre-empts the running fetch.

  lfs_state_t        r_state;
  logic [9:0]        r_drawy;
  logic [NES_XW-1:0] r_x;
  logic              r_wr_bank;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_line_ready;
  logic              r_underrun;
  logic              r_pix_valid;

  logic              w_trig;
  logic [NES_XW-1:0] w_trig_line;
  logic              w_in_win;
  logic [NES_XW-1:0] w_rd_x;
  logic              w_rd_bank;
  logic              w_wr_en;
  pal_idx_t          w_rd_data;

  // Row-change detector: line 0 is loaded during the last blanking row, every
  // other line one row-pair ahead of the row pair that displays it.
  always_comb begin
    w_trig      = 1'b0;
    w_trig_line = '0;
    if (DrawY != r_drawy) begin
      if (DrawY == LINE0_TRIG_Y) begin
        w_trig      = 1'b1;
        w_trig_line = '0;
      end else if (!DrawY[0] && (DrawY < TRIG_Y_LIMIT)) begin
        w_trig      = 1'b1;
        w_trig_line = DrawY[8:1] + 8'd1;
      end
    end
  end

  assign w_in_win  = (DrawX >= WIN_X_LO) && (DrawX < WIN_X_HI) && (DrawY < WIN_Y_HI);
  assign w_rd_x    = NES_XW'((DrawX - WIN_X_LO) >> 1);
  assign w_rd_bank = DrawY[1];
  // A pre-empting trigger wins over a same-cycle ack: that word belongs to the abandoned line.
  assign w_wr_en   = (r_state == FETCH) && r_mem_req && mem_ack && !w_trig;

  line_buffer_2x u_line_buffer (
    .i_clk     (Clk),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (r_x),
    .i_wr_data (mem_rdata),
    .i_rd_bank (w_rd_bank),
    .i_rd_addr (w_rd_x),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_drawy      <= '0;
      r_x          <= '0;
      r_wr_bank    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_line_ready <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_drawy      <= DrawY;
      r_line_ready <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_trig) begin
            r_state    <= FETCH;
            r_x        <= '0;
            r_wr_bank  <= w_trig_line[0];
            r_mem_req  <= 1'b1;
            r_mem_addr <= line_base_addr(w_trig_line);
          end else begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
          end
        end
        FETCH: begin
          if (w_trig) begin
            r_state    <= FETCH;
            r_x        <= '0;
            r_wr_bank  <= w_trig_line[0];
            r_mem_req  <= 1'b1;
            r_mem_addr <= line_base_addr(w_trig_line);
            r_underrun <= 1'b1;
          end else if (mem_ack) begin
            if (r_x == LAST_X) begin
              r_state      <= DONE;
              r_mem_req    <= 1'b0;
              r_line_ready <= 1'b1;
            end else begin
              r_x        <= r_x + 8'd1;
              r_mem_addr <= r_mem_addr + 16'd1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_pix_valid <= 1'b0;
    else       r_pix_valid <= w_in_win;
  end

`ifdef LFS_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_underrun_cnt <= '0;
    end else if ((r_state == FETCH) && w_trig && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`else
  assign underrun_cnt = 8'h00;
`endif

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign line_ready = r_line_ready;
  assign underrun   = r_underrun;
  assign pix_valid  = r_pix_valid;
  assign pix_index  = r_pix_valid ? w_rd_data : BORDER_IDX;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Self-checking bench for line_fetch_scheduler: scripted row sequences with
// randomized pixel columns and ack patterns, checked against a geometric model.
module tb_line_fetch_scheduler;
  import lfs_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [5:0]  mem_rdata;
  logic [5:0]  pix_index;
  logic        pix_valid, line_ready, underrun;
  logic [7:0]  underrun_cnt;
  lfs_state_t  dbg_state;

  line_fetch_scheduler dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pix_index(pix_index), .pix_valid(pix_valid), .line_ready(line_ready),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] acc_q[$];
  int          acc_cyc[$];
  int cyc = 0;
  int ready_cnt = 0;
  int ready_base = 0;
  int bank_line[2] = '{-1, -1};
  int ack_mode = 0;
  int ack_tick = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame memory model: every word carries bits of both its column and its line.
  function automatic logic [5:0] data_fn(input int a);
    return 6'((a % 64) ^ ((a / 256) % 64));
  endfunction

  assign mem_rdata = data_fn(int'(mem_addr));

  always @(negedge Clk) begin
    ack_tick++;
    case (ack_mode)
      1:       mem_ack = 1'b1;
      2:       mem_ack = (ack_tick % 8 == 0);
      3:       mem_ack = 1'($urandom_range(0, 1));
      default: mem_ack = 1'b0;
    endcase
  end

  always @(posedge Clk) begin
    cyc++;
    if (!Reset && mem_req && mem_ack) begin
      acc_q.push_back(mem_addr);
      acc_cyc.push_back(cyc);
    end
    if (!Reset && line_ready) ready_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_fetch(input int y, input int line);
    acc_q.delete();
    acc_cyc.delete();
    ready_base = ready_cnt;
    bank_line[line % 2] = -1;
    DrawY = 10'(y);
  endtask

  task automatic finish_fetch(input int line, input int budget, input bit chk_burst);
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int waited;
    waited = 0;
    while (ready_cnt == ready_base && waited < budget) begin
      @(negedge Clk);
      waited++;
    end
    if (ready_cnt == ready_base) begin
      check_eq($sformatf("fetch_timeout_line%0d", line), 32'd0, 32'd1);
      return;
    end
    check_eq("ready_pulses", 32'(ready_cnt - ready_base), 32'd1);
    check_eq("req_after_done", 32'(mem_req), 32'd0);
    check_eq("ready_low_after", 32'(line_ready), 32'd0);
    check_eq("state_after_done", 32'(dbg_state), 32'(IDLE));
    check_eq("fetch_len", 32'(acc_q.size()), 32'(NES_W));
    for (int i = 0; i < NES_W; i++) exp_q.push_back(16'(line * NES_W + i));
    for (int i = 0; i < acc_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      check_eq($sformatf("fetch_addr[%0d]", i), 32'(acc_q[i]), 32'(e));
      if (acc_q[i] != e) break;
    end
    if (chk_burst && acc_q.size() == NES_W)
      check_eq("burst_span", 32'(acc_cyc[NES_W-1] - acc_cyc[0]), 32'(NES_W - 1));
    bank_line[line % 2] = line;
  endtask

  task automatic pix_check(input int x, input int y);
    int  l;
    bit  inwin;
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge Clk);
    l = y / 2;
    inwin = (x >= X_OFFSET) && (x < X_OFFSET + 2 * NES_W) && (y < V_ACTIVE);
    check_eq($sformatf("pix_valid(%0d,%0d)", x, y), 32'(pix_valid), 32'(inwin));
    if (!inwin)
      check_eq($sformatf("pix_border(%0d,%0d)", x, y), 32'(pix_index), 32'h0F);
    else if (bank_line[l % 2] == l)
      check_eq($sformatf("pix_index(%0d,%0d)", x, y), 32'(pix_index),
               32'(data_fn(l * NES_W + (x - X_OFFSET) / 2)));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req"},      32'(mem_req),      32'd0);
    check_eq({tag, "_addr"},     32'(mem_addr),     32'd0);
    check_eq({tag, "_pix"},      32'(pix_index),    32'h0F);
    check_eq({tag, "_valid"},    32'(pix_valid),    32'd0);
    check_eq({tag, "_ready"},    32'(line_ready),   32'd0);
    check_eq({tag, "_underrun"}, 32'(underrun),     32'd0);
    check_eq({tag, "_cnt"},      32'(underrun_cnt), 32'd0);
    check_eq({tag, "_state"},    32'(dbg_state),    32'(IDLE));
  endtask

  function automatic int exp_cnt(input int n);
`ifdef LFS_UNDERRUN_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    int fixed_x[8] = '{64, 65, 66, 63, 575, 576, 0, 639};
    Reset = 1'b1; DrawX = '0; DrawY = '0; ack_mode = 1;
    repeat (3) @(negedge Clk);
    check_reset_values("reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("idle_no_trigger_req", 32'(mem_req), 32'd0);

    // Line 0 prefetch with ack tied high.
    start_fetch(524, 0);
    finish_fetch(0, 400, 1'b1);
    repeat (5) @(negedge Clk);
    check_eq("single_ready_pulse", 32'(ready_cnt - ready_base), 32'd1);
    check_eq("req_stays_low", 32'(mem_req), 32'd0);
    check_eq("no_underrun_yet", 32'(underrun), 32'd0);

    // Row 0 fetches line 1; then display lines 0.
    start_fetch(0, 1);
    finish_fetch(1, 400, 1'b1);
    foreach (fixed_x[i]) pix_check(fixed_x[i], 0);
    repeat (15) pix_check($urandom_range(0, 799), 0);
    repeat (15) pix_check($urandom_range(0, 799), 1);

    // Random ack pacing; line 1 on display while bank 0 fills.
    ack_mode = 3;
    start_fetch(2, 2);
    repeat (20) pix_check($urandom_range(40, 600), 2);
    finish_fetch(2, 3000, 1'b0);
    repeat (10) pix_check($urandom_range(40, 600), 3);
    start_fetch(4, 3);
    repeat (20) pix_check($urandom_range(40, 600), 4);
    finish_fetch(3, 3000, 1'b0);

    // Slow memory: the next trigger pre-empts the fetch.
    ack_mode = 2;
    start_fetch(6, 4);
    repeat (600) @(negedge Clk);
    check_eq("slow_still_fetching", 32'(dbg_state), 32'(FETCH));
    check_eq("slow_no_underrun", 32'(underrun), 32'd0);
    DrawY = 10'd7;
    repeat (3) @(negedge Clk);
    check_eq("odd_row_no_underrun", 32'(underrun), 32'd0);
    DrawY = 10'd8;
    @(negedge Clk);
    check_eq("underrun_set", 32'(underrun), 32'd1);
    check_eq("underrun_cnt_1", 32'(underrun_cnt), 32'(exp_cnt(1)));
    check_eq("restart_req", 32'(mem_req), 32'd1);
    check_eq("restart_addr", 32'(mem_addr), 32'(5 * NES_W));
    check_eq("restart_state", 32'(dbg_state), 32'(FETCH));
    for (int k = 0; k < 260; k++) begin
      DrawY = (k % 2 == 0) ? 10'd10 : 10'd12;
      @(negedge Clk);
      if (k == 99) check_eq("underrun_cnt_101", 32'(underrun_cnt), 32'(exp_cnt(101)));
    end
    check_eq("underrun_cnt_sat", 32'(underrun_cnt), 32'(exp_cnt(261)));
    check_eq("underrun_sticky", 32'(underrun), 32'd1);
    check_eq("last_restart_addr", 32'(mem_addr), 32'(7 * NES_W));
    ready_base = ready_cnt;
    ack_mode = 1;
    waited = 0;
    while (ready_cnt == ready_base && waited < 600) begin
      @(negedge Clk);
      waited++;
    end
    check_eq("line7_completes", 32'(ready_cnt - ready_base), 32'd1);
    bank_line[0] = -1;
    bank_line[1] = 7;

    // Reset in the middle of a fetch.
    ack_mode = 0;
    start_fetch(14, 8);
    repeat (10) pix_check($urandom_range(40, 600), 14);
    check_eq("stall_req_held", 32'(mem_req), 32'd1);
    check_eq("stall_addr_held", 32'(mem_addr), 32'(8 * NES_W));
    ack_mode = 1;
    waited = 0;
    while (acc_q.size() < 100 && waited < 400) begin
      @(negedge Clk);
      waited++;
    end
    check_eq("reached_x100", 32'(acc_q.size()), 32'd100);
    check_eq("addr_at_x100", 32'(mem_addr), 32'(8 * NES_W + 100));
    #2;
    Reset = 1'b1;
    DrawY = 10'd15;
    #1;
    check_reset_values("midreset");
    @(negedge Clk);
    Reset = 1'b0;
    bank_line[0] = -1;
    bank_line[1] = -1;
    repeat (2) @(negedge Clk);
    check_eq("post_reset_idle", 32'(mem_req), 32'd0);
    start_fetch(16, 9);
    finish_fetch(9, 400, 1'b1);
    check_eq("post_reset_underrun_clear", 32'(underrun), 32'd0);

    // Last NES line, then the non-triggering tail of the frame.
    start_fetch(476, 239);
    finish_fetch(239, 400, 1'b1);
    for (int y = 478; y <= 523; y++) begin
      DrawX = 10'($urandom_range(64, 575));
      DrawY = 10'(y);
      @(negedge Clk);
      check_eq($sformatf("tail_req_y%0d", y), 32'(mem_req), 32'd0);
      check_eq($sformatf("tail_valid_y%0d", y), 32'(pix_valid), (y < 480) ? 32'd1 : 32'd0);
      if (y >= 480) check_eq($sformatf("tail_pix_y%0d", y), 32'(pix_index), 32'h0F);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
